// File: rtl/pool_if.sv
// Handshake/bus bundle for pool_engine: run control, feature-map BRAM read port,
// pooled-activation BRAM write port and status.
interface pool_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_IN_W  = 13,
   parameter int ADDR_OUT_W = 11
);
   logic                         start;
   logic                         mode;
   logic [ADDR_IN_W-1:0]         conv_addr;
   logic                         conv_en;
   logic signed [DATA_WIDTH-1:0] conv_q;
   logic [ADDR_OUT_W-1:0]        pool_addr;
   logic                         pool_en;
   logic                         pool_we;
   logic signed [DATA_WIDTH-1:0] pool_d;
   logic                         busy;
   logic                         done;

   modport master (
      output start, mode, conv_q,
      input  conv_addr, conv_en, pool_addr, pool_en, pool_we, pool_d, busy, done
   );

   modport slave (
      input  start, mode, conv_q,
      output conv_addr, conv_en, pool_addr, pool_en, pool_we, pool_d, busy, done
   );
endinterface

// File: rtl/pool_engine.sv
// Pipelined POOLxPOOL max/average pooling engine, one BRAM read per cycle.
// Optional fused ReLU on the written result when POOL_RELU_EN is defined.
module pool_engine #(
   parameter int DATA_WIDTH = 16,
   parameter int CHANNELS   = 8,
   parameter int IN_SIZE    = 28,
   parameter int POOL       = 2,
   parameter int BRAM_LAT   = 1
) (
   input logic   clk,
   input logic   reset,
   pool_if.slave bus
);
   localparam int OUT    = IN_SIZE / POOL;
   localparam int LOGP   = $clog2(POOL);
   localparam int ACC_W  = DATA_WIDTH + 2 * LOGP;
   localparam int AW_IN  = $clog2(CHANNELS * IN_SIZE * IN_SIZE);
   localparam int AW_OUT = $clog2(CHANNELS * OUT * OUT);
   localparam int QW     = $clog2(OUT) + 1;
   localparam int CW     = $clog2(CHANNELS) + 1;

   localparam logic [AW_IN-1:0] STEP_DY = AW_IN'(IN_SIZE - POOL + 1);
   localparam logic [AW_IN-1:0] STEP_Q  = AW_IN'(POOL);
   localparam logic [AW_IN-1:0] STEP_R  = AW_IN'(POOL * IN_SIZE);
   localparam logic [AW_IN-1:0] STEP_CH = AW_IN'(IN_SIZE * IN_SIZE);
   localparam logic [LOGP-1:0]  DMAX    = LOGP'(POOL - 1);
   localparam logic [QW-1:0]    QMAX    = QW'(OUT - 1);
   localparam logic [CW-1:0]    CMAX    = CW'(CHANNELS - 1);

   generate
      if (POOL < 2 || (POOL & (POOL - 1)) != 0) begin : g_bad_pool
         $error("pool_engine: POOL must be a power of two >= 2");
      end
      if (BRAM_LAT < 1 || BRAM_LAT > 4) begin : g_bad_lat
         $error("pool_engine: BRAM_LAT must be in 1..4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;
   state_t state, state_n;

   logic [LOGP-1:0]  dx, dy;
   logic [QW-1:0]    q, r;
   logic [CW-1:0]    ch;
   logic [AW_IN-1:0] addr, win, row, chb;
   logic [AW_IN-1:0] win_nq, row_nr, chb_nc;
   logic             mode_r;
   logic             conv_en, busy, done;
   logic             first_rd, last_win, last_rd;

   logic [BRAM_LAT-1:0] vld_pipe, fst_pipe, lst_pipe;
   logic                cap_v, cap_f, cap_l;

   logic signed [ACC_W-1:0]      acc, acc_n, q_ext, res_w;
   logic signed [DATA_WIDTH-1:0] res_o, pool_d_r;
   logic [AW_OUT-1:0]            pool_addr_r, wr_cnt;
   logic                         pool_en_r;

   assign first_rd = (dx == '0) && (dy == '0);
   assign last_win = (dx == DMAX) && (dy == DMAX);
   assign last_rd  = last_win && (q == QMAX) && (r == QMAX) && (ch == CMAX);
   assign win_nq   = win + STEP_Q;
   assign row_nr   = row + STEP_R;
   assign chb_nc   = chb + STEP_CH;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      conv_en = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state)
         IDLE:   if (bus.start) state_n = RUN;
         RUN: begin
            conv_en = 1'b1;
            busy    = 1'b1;
            if (last_rd) state_n = DRAIN;
         end
         // Once the last tag has left the pipe, a pending write is the final one.
         DRAIN: begin
            busy = 1'b1;
            if (pool_en_r && vld_pipe == '0) state_n = FINISH;
         end
         FINISH: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Window walk: addr tracks dx/dy inside the window, win/row/chb hold the
   // window, window-row and channel base addresses so every step is one add.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dx <= '0; dy <= '0; q <= '0; r <= '0; ch <= '0;
         addr <= '0; win <= '0; row <= '0; chb <= '0;
         mode_r <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         dx <= '0; dy <= '0; q <= '0; r <= '0; ch <= '0;
         addr <= '0; win <= '0; row <= '0; chb <= '0;
         mode_r <= bus.mode;
      end else if (state == RUN) begin
         if (dx != DMAX) begin
            dx   <= dx + LOGP'(1);
            addr <= addr + AW_IN'(1);
         end else begin
            dx <= '0;
            if (dy != DMAX) begin
               dy   <= dy + LOGP'(1);
               addr <= addr + STEP_DY;
            end else begin
               dy <= '0;
               if (q != QMAX) begin
                  q    <= q + QW'(1);
                  win  <= win_nq;
                  addr <= win_nq;
               end else begin
                  q <= '0;
                  if (r != QMAX) begin
                     r    <= r + QW'(1);
                     row  <= row_nr;
                     win  <= row_nr;
                     addr <= row_nr;
                  end else begin
                     r    <= '0;
                     ch   <= ch + CW'(1);
                     chb  <= chb_nc;
                     row  <= chb_nc;
                     win  <= chb_nc;
                     addr <= chb_nc;
                  end
               end
            end
         end
      end
   end

   assign cap_v = vld_pipe[BRAM_LAT-1];
   assign cap_f = fst_pipe[BRAM_LAT-1];
   assign cap_l = lst_pipe[BRAM_LAT-1];
   assign q_ext = {{(ACC_W - DATA_WIDTH){bus.conv_q[DATA_WIDTH-1]}}, bus.conv_q};

   always_comb begin
      if (cap_f)                acc_n = q_ext;
      else if (mode_r)          acc_n = acc + q_ext;
      else if (q_ext > acc)     acc_n = q_ext;
      else                      acc_n = acc;
      // Sum of POOL^2 words shifted by 2*log2(POOL): floor mean, always in range.
      res_w = mode_r ? (acc_n >>> (2 * LOGP)) : acc_n;
`ifdef POOL_RELU_EN
      res_o = res_w[ACC_W-1] ? '0 : DATA_WIDTH'(res_w);
`else
      res_o = DATA_WIDTH'(res_w);
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe    <= '0;
         fst_pipe    <= '0;
         lst_pipe    <= '0;
         acc         <= '0;
         pool_en_r   <= 1'b0;
         pool_d_r    <= '0;
         pool_addr_r <= '0;
         wr_cnt      <= '0;
      end else begin
         vld_pipe[0] <= conv_en;
         fst_pipe[0] <= conv_en & first_rd;
         lst_pipe[0] <= conv_en & last_win;
         for (int i = 1; i < BRAM_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            fst_pipe[i] <= fst_pipe[i-1];
            lst_pipe[i] <= lst_pipe[i-1];
         end
         if (cap_v) acc <= acc_n;
         pool_en_r <= cap_v & cap_l;
         if (cap_v && cap_l) begin
            pool_d_r    <= res_o;
            pool_addr_r <= wr_cnt;
            wr_cnt      <= wr_cnt + AW_OUT'(1);
         end else if (state == IDLE && bus.start) begin
            wr_cnt <= '0;
         end
      end
   end

   assign bus.conv_addr = addr;
   assign bus.conv_en   = conv_en;
   assign bus.pool_addr = pool_addr_r;
   assign bus.pool_en   = pool_en_r;
   assign bus.pool_we   = pool_en_r;
   assign bus.pool_d    = pool_d_r;
   assign bus.busy      = busy;
   assign bus.done      = done;
endmodule

// File: tb/tb_pool_engine.sv
// Scoreboard bench for pool_engine: one small POOL=2 instance for directed
// tests plus three POOL=4 instances swept over BRAM read latency.
module tb_pool_engine;
   localparam int NI = 4;
   localparam int CFG_CH  [NI] = '{1, 2, 2, 2};
   localparam int CFG_IN  [NI] = '{4, 10, 10, 10};
   localparam int CFG_P   [NI] = '{2, 4, 4, 4};
   localparam int CFG_LAT [NI] = '{1, 1, 2, 4};

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int checks = 0;
   int failures = 0;

   logic              rst_s   [NI];
   logic              start_s [NI];
   logic              mode_s  [NI];
   logic signed [15:0] mem    [NI][256];
   exp_t              exp_q   [NI][$];
   int                exp_done[NI];
   int                done_cnt[NI];
   int                t0      [NI];
   bit                arm     [NI];

   logic               conv_en_w  [NI];
   logic               busy_w     [NI];
   logic               done_w     [NI];
   logic               pool_en_w  [NI];
   logic [15:0]        conv_addr_w[NI];
   logic [15:0]        pool_addr_w[NI];
   logic signed [15:0] pool_d_w   [NI];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int relu(input int x);
`ifdef POOL_RELU_EN
      return (x < 0) ? 0 : x;
`else
      return x;
`endif
   endfunction

   function automatic int floor_div(input int s, input int c);
      if (s < 0 && (s % c) != 0) return s / c - 1;
      return s / c;
   endfunction

   function automatic int ref_win(input int g, input logic m, input int c, input int r, input int q);
      int p, in, s, mx, v;
      p = CFG_P[g]; in = CFG_IN[g]; s = 0; mx = -100000;
      for (int dy = 0; dy < p; dy++)
         for (int dx = 0; dx < p; dx++) begin
            v = int'(mem[g][c*in*in + (p*r + dy)*in + p*q + dx]);
            s += v;
            if (v > mx) mx = v;
         end
      return relu(m ? floor_div(s, p*p) : mx);
   endfunction

   for (genvar g = 0; g < NI; g++) begin : gi
      localparam int CH  = CFG_CH[g];
      localparam int IN  = CFG_IN[g];
      localparam int P   = CFG_P[g];
      localparam int LAT = CFG_LAT[g];
      localparam int OUT = IN / P;
      localparam int AIW = $clog2(CH*IN*IN);
      localparam int AOW = $clog2(CH*OUT*OUT);

      pool_if #(.DATA_WIDTH(16), .ADDR_IN_W(AIW), .ADDR_OUT_W(AOW)) bus ();

      pool_engine #(
         .DATA_WIDTH(16), .CHANNELS(CH), .IN_SIZE(IN), .POOL(P), .BRAM_LAT(LAT)
      ) dut (
         .clk(clk), .reset(rst_s[g]), .bus(bus)
      );

      assign bus.start = start_s[g];
      assign bus.mode  = mode_s[g];

      // BRAM model; garbage when not enabled so untagged data must be ignored.
      logic signed [15:0] qpipe [LAT];
      always @(posedge clk) begin
         qpipe[0] <= bus.conv_en ? mem[g][int'(bus.conv_addr)] : 16'sh5A5A;
         for (int i = 1; i < LAT; i++) qpipe[i] <= qpipe[i-1];
      end
      assign bus.conv_q = qpipe[LAT-1];

      assign conv_en_w[g]   = bus.conv_en;
      assign busy_w[g]      = bus.busy;
      assign done_w[g]      = bus.done;
      assign pool_en_w[g]   = bus.pool_en;
      assign conv_addr_w[g] = 16'(bus.conv_addr);
      assign pool_addr_w[g] = 16'(bus.pool_addr);
      assign pool_d_w[g]    = bus.pool_d;

      always @(negedge clk) begin : mon
         exp_t e;
         int rem;
         if (arm[g] && cyc == t0[g] + 1) begin
            arm[g] = 1'b0;
            chk($sformatf("first_rd_en[%0d]", g), int'(bus.conv_en), 1);
            chk($sformatf("first_rd_addr[%0d]", g), int'(bus.conv_addr), 0);
            chk($sformatf("busy_run[%0d]", g), int'(bus.busy), 1);
         end
         if (bus.conv_en && !rst_s[g]) begin
            rem = int'(bus.conv_addr) % (IN*IN);
            chk($sformatf("rd_in_window[%0d] addr=%0d", g, bus.conv_addr),
                int'((rem / IN) < OUT*P && (rem % IN) < OUT*P), 1);
         end
         if (bus.pool_en) begin
            chk($sformatf("we_eq_en[%0d]", g), int'(bus.pool_we), 1);
            if (exp_q[g].size() == 0) begin
               chk($sformatf("unexpected_write[%0d]", g), 1, 0);
            end else begin
               e = exp_q[g].pop_front();
               chk($sformatf("wr_addr[%0d]", g), int'(bus.pool_addr), int'(e.addr));
               chk($sformatf("wr_data[%0d] @%0d", g, e.addr), int'(bus.pool_d), int'($signed(e.data)));
            end
         end
         if (bus.done) begin
            done_cnt[g]++;
            chk($sformatf("done_cycle[%0d]", g), cyc, exp_done[g]);
            chk($sformatf("busy_at_done[%0d]", g), int'(bus.busy), 0);
         end
      end
   end

   task automatic push_exp(input int g, input int a, input int d);
      exp_t e;
      e.addr = 16'(a);
      e.data = 16'(d);
      exp_q[g].push_back(e);
   endtask

   // Called at a negedge; that cycle is cycle 0 of the run.
   task automatic launch(input int g, input logic m, input bit model);
      int p, out, n, idx;
      p = CFG_P[g]; out = CFG_IN[g] / p;
      n = CFG_CH[g] * out * out * p * p;
      if (model) begin
         idx = 0;
         for (int c = 0; c < CFG_CH[g]; c++)
            for (int r = 0; r < out; r++)
               for (int q = 0; q < out; q++) begin
                  push_exp(g, idx, ref_win(g, m, c, r, q));
                  idx++;
               end
      end
      t0[g]       = cyc;
      arm[g]      = 1'b1;
      exp_done[g] = cyc + n + CFG_LAT[g] + 2;
      start_s[g]  = 1'b1;
      mode_s[g]   = m;
   endtask

   task automatic wait_done(input int g, input int budget);
      int k;
      k = 0;
      while (!done_w[g] && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (!done_w[g]) chk($sformatf("timeout_done[%0d]", g), 0, 1);
      @(negedge clk);
      chk($sformatf("queue_empty[%0d]", g), exp_q[g].size(), 0);
   endtask

   task automatic load_table();
      int tbl [16];
      tbl = '{-1, -2, 1, 2,
              -3, -4, 3, 5,
              100, -100, -32768, -32768,
              7, -8, -32768, -32768};
      for (int a = 0; a < 16; a++) mem[0][a] = 16'(tbl[a]);
   endtask

   task automatic push_table(input logic m);
      if (m) begin
         push_exp(0, 0, relu(-3)); push_exp(0, 1, relu(2));
         push_exp(0, 2, relu(-1)); push_exp(0, 3, relu(-32768));
      end else begin
         push_exp(0, 0, relu(-1)); push_exp(0, 1, relu(5));
         push_exp(0, 2, relu(100)); push_exp(0, 3, relu(-32768));
      end
   endtask

   initial begin
      int d0, row, col;
      for (int g = 0; g < NI; g++) begin
         rst_s[g] = 1'b1; start_s[g] = 1'b0; mode_s[g] = 1'b0;
         done_cnt[g] = 0; arm[g] = 1'b0; exp_done[g] = -1; t0[g] = 0;
      end
      for (int a = 0; a < 16; a++) mem[0][a] = 16'(a);
      for (int a = 0; a < 256; a++) begin
         row = (a % 100) / 10; col = a % 10;
         for (int g = 1; g < NI; g++)
            mem[g][a] = (row >= 8 || col >= 8) ? 16'sd30000 : 16'(((a * 37) % 211) - 105);
      end

      repeat (2) @(negedge clk);
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("rst_busy[%0d]", g), int'(busy_w[g]), 0);
         chk($sformatf("rst_conv_en[%0d]", g), int'(conv_en_w[g]), 0);
      end
      chk("rst_conv_addr", int'(conv_addr_w[0]), 0);
      chk("rst_pool_en", int'(pool_en_w[0]), 0);
      chk("rst_pool_addr", int'(pool_addr_w[0]), 0);
      chk("rst_pool_d", int'(pool_d_w[0]), 0);
      chk("rst_done", int'(done_w[0]), 0);
      for (int g = 0; g < NI; g++) rst_s[g] = 1'b0;
      @(negedge clk);

      // Max mode over 0..15: done in cycle 19.
      push_exp(0, 0, 5); push_exp(0, 1, 7); push_exp(0, 2, 13); push_exp(0, 3, 15);
      launch(0, 1'b0, 1'b0);
      @(negedge clk); start_s[0] = 1'b0;
      wait_done(0, 100);

      // Average with negatives, then max on the same data (ReLU visible here).
      load_table();
      push_table(1'b1);
      launch(0, 1'b1, 1'b0);
      @(negedge clk); start_s[0] = 1'b0;
      wait_done(0, 100);
      push_table(1'b0);
      launch(0, 1'b0, 1'b0);
      @(negedge clk); start_s[0] = 1'b0;
      wait_done(0, 100);

      // Start held and mode toggling for the whole run.
      d0 = done_cnt[0];
      push_table(1'b1);
      launch(0, 1'b1, 1'b0);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (done_w[0]) break;
         mode_s[0] = ~mode_s[0];
      end
      start_s[0] = 1'b0;
      if (!done_w[0]) chk("timeout_hold_start", 0, 1);
      repeat (10) @(negedge clk);
      chk("single_done", done_cnt[0] - d0, 1);
      chk("idle_after_hold", int'(busy_w[0]), 0);
      chk("queue_empty_hold", exp_q[0].size(), 0);

      // Asynchronous reset between edges in the middle of RUN.
      push_table(1'b0);
      launch(0, 1'b0, 1'b0);
      @(negedge clk); start_s[0] = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_s[0] = 1'b1;
      #1;
      chk("arst_conv_en", int'(conv_en_w[0]), 0);
      chk("arst_conv_addr", int'(conv_addr_w[0]), 0);
      chk("arst_busy", int'(busy_w[0]), 0);
      chk("arst_pool_en", int'(pool_en_w[0]), 0);
      chk("arst_pool_d", int'(pool_d_w[0]), 0);
      chk("arst_done", int'(done_w[0]), 0);
      exp_q[0].delete();
      arm[0] = 1'b0;
      @(negedge clk); rst_s[0] = 1'b0;
      @(negedge clk);
      push_table(1'b0);
      launch(0, 1'b0, 1'b0);
      @(negedge clk); start_s[0] = 1'b0;
      wait_done(0, 100);

      // POOL=4, IN_SIZE=10 across BRAM_LAT 1/2/4, max then average.
      for (int m = 0; m < 2; m++) begin
         for (int g = 1; g < NI; g++) launch(g, m[0], 1'b1);
         @(negedge clk);
         for (int g = 1; g < NI; g++) start_s[g] = 1'b0;
         wait_done(1, 400);
         wait_done(2, 20);
         wait_done(3, 20);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end
endmodule
